// File: rtl/cm_loop3_agen.sv
// Three-level nested-loop address generator (col inner, row middle, ch outer) feeding the ibuf
// write path. It emits one address/index beat per valid/ready transfer, then a one-cycle done pulse.
module cm_loop3_agen #(
  parameter int unsigned C_WIDTH  = 8,
  parameter int unsigned C_AWIDTH = 16
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_start,
  input  logic [C_WIDTH-1:0]  I_col_upper,
  input  logic [C_WIDTH-1:0]  I_row_upper,
  input  logic [C_WIDTH-1:0]  I_ch_upper,
  input  logic [C_AWIDTH-1:0] I_base_addr,
  input  logic [C_AWIDTH-1:0] I_row_stride,
  input  logic [C_AWIDTH-1:0] I_ch_stride,
  input  logic                I_ready,
  output logic                O_valid,
  output logic [C_AWIDTH-1:0] O_addr,
  output logic [C_WIDTH-1:0]  O_col,
  output logic [C_WIDTH-1:0]  O_row,
  output logic [C_WIDTH-1:0]  O_ch,
  output logic                O_col_last,
  output logic                O_row_last,
  output logic                O_ch_last,
  output logic                O_busy,
  output logic                O_done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [C_WIDTH-1:0] CntOne = C_WIDTH'(1);

  state_e              state_q;
  logic                valid_q;
  logic                done_q;
  logic [C_WIDTH-1:0]  col_q, row_q, ch_q;
  logic [C_WIDTH-1:0]  col_up_q, row_up_q, ch_up_q;
  logic [C_AWIDTH-1:0] base_q, row_stride_q, ch_stride_q;
  logic [C_AWIDTH-1:0] row_acc_q, ch_acc_q;

  logic xfer;
  logic col_last, row_last, ch_last;
  logic any_zero;

  assign xfer     = valid_q && I_ready;
  assign col_last = valid_q && (col_q == col_up_q - CntOne);
  assign row_last = valid_q && (row_q == row_up_q - CntOne);
  assign ch_last  = valid_q && (ch_q == ch_up_q - CntOne);
  assign any_zero = (I_col_upper == '0) || (I_row_upper == '0) || (I_ch_upper == '0);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
      ch_q         <= '0;
      col_up_q     <= '0;
      row_up_q     <= '0;
      ch_up_q      <= '0;
      base_q       <= '0;
      row_stride_q <= '0;
      ch_stride_q  <= '0;
      row_acc_q    <= '0;
      ch_acc_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (I_start) begin
            col_up_q     <= I_col_upper;
            row_up_q     <= I_row_upper;
            ch_up_q      <= I_ch_upper;
            base_q       <= I_base_addr;
            row_stride_q <= I_row_stride;
            ch_stride_q  <= I_ch_stride;
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            row_acc_q    <= '0;
            ch_acc_q     <= '0;
            // An empty loop nest still reports completion so the consumer never stalls.
            if (any_zero) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              valid_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (xfer) begin
            if (!col_last) begin
              col_q <= col_q + CntOne;
            end else begin
              col_q <= '0;
              if (!row_last) begin
                row_q     <= row_q + CntOne;
                row_acc_q <= row_acc_q + row_stride_q;
              end else begin
                row_q     <= '0;
                row_acc_q <= '0;
                if (!ch_last) begin
                  ch_q     <= ch_q + CntOne;
                  ch_acc_q <= ch_acc_q + ch_stride_q;
                end else begin
                  ch_q     <= '0;
                  ch_acc_q <= '0;
                  valid_q  <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
                end
              end
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          valid_q <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Address is forced to zero between runs so idle outputs match the reset state.
  assign O_addr     = valid_q ? (base_q + ch_acc_q + row_acc_q + C_AWIDTH'(col_q)) : '0;
  assign O_valid    = valid_q;
  assign O_col      = col_q;
  assign O_row      = row_q;
  assign O_ch       = ch_q;
  assign O_col_last = col_last;
  assign O_row_last = row_last;
  assign O_ch_last  = ch_last;
  assign O_busy     = (state_q != StIdle);
  assign O_done     = done_q;

endmodule

// File: tb/tb_cm_loop3_agen.sv
// Bench for cm_loop3_agen: directed config table, reset/abort sequences and random configs,
// each beat compared against a nested-loop reference model.
module tb_cm_loop3_agen;

  logic        I_clk;
  logic        I_rst_n;
  logic        I_start;
  logic [7:0]  I_col_upper, I_row_upper, I_ch_upper;
  logic [15:0] I_base_addr, I_row_stride, I_ch_stride;
  logic        I_ready;
  logic        O_valid;
  logic [15:0] O_addr;
  logic [7:0]  O_col, O_row, O_ch;
  logic        O_col_last, O_row_last, O_ch_last;
  logic        O_busy, O_done;

  cm_loop3_agen #(
    .C_WIDTH (8),
    .C_AWIDTH(16)
  ) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_start     (I_start),
    .I_col_upper (I_col_upper),
    .I_row_upper (I_row_upper),
    .I_ch_upper  (I_ch_upper),
    .I_base_addr (I_base_addr),
    .I_row_stride(I_row_stride),
    .I_ch_stride (I_ch_stride),
    .I_ready     (I_ready),
    .O_valid     (O_valid),
    .O_addr      (O_addr),
    .O_col       (O_col),
    .O_row       (O_row),
    .O_ch        (O_ch),
    .O_col_last  (O_col_last),
    .O_row_last  (O_row_last),
    .O_ch_last   (O_ch_last),
    .O_busy      (O_busy),
    .O_done      (O_done)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  typedef struct {
    int unsigned cu, ru, chu;
    logic [15:0] base, rs, cs;
    int          rdy;
    bit          poke;
    int unsigned exp_beats;
    logic [15:0] exp_first, exp_last;
  } vec_t;

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;
  logic [15:0] obs_q[$];
  logic [15:0] sweep_addr[12];
  vec_t        vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return 64'({O_valid, O_done, O_busy, O_addr, O_col, O_row, O_ch,
                O_col_last, O_row_last, O_ch_last});
  endfunction

  // Runs one full transaction; the expected stream comes from plain nested loops.
  task automatic run_cfg(input int unsigned cu, input int unsigned ru, input int unsigned chu,
                         input logic [15:0] base, input logic [15:0] rs, input logic [15:0] cs,
                         input int rdy, input bit poke, output int unsigned nobs);
    logic [63:0] exp_q[$];
    logic [15:0] a;
    int unsigned idx;
    int          cyc;
    bit          rd, v_s;
    obs_q.delete();
    for (int c = 0; c < int'(chu); c++)
      for (int r = 0; r < int'(ru); r++)
        for (int k = 0; k < int'(cu); k++) begin
          a = base + 16'(c) * cs + 16'(r) * rs + 16'(k);
          exp_q.push_back(64'({1'b1, 1'b0, 1'b1, a, 8'(k), 8'(r), 8'(c),
                               k == int'(cu) - 1, r == int'(ru) - 1, c == int'(chu) - 1}));
        end
    @(negedge I_clk);
    I_col_upper  = cu[7:0];
    I_row_upper  = ru[7:0];
    I_ch_upper   = chu[7:0];
    I_base_addr  = base;
    I_row_stride = rs;
    I_ch_stride  = cs;
    I_ready      = 1'b0;
    I_start      = 1'b1;
    @(negedge I_clk);
    I_start      = 1'b0;
    // Configuration inputs are free to change once the start has been taken.
    I_col_upper  = 8'($urandom);
    I_row_upper  = 8'($urandom);
    I_ch_upper   = 8'($urandom);
    I_base_addr  = 16'($urandom);
    I_row_stride = 16'($urandom);
    I_ch_stride  = 16'($urandom);
    if (exp_q.size() == 0) begin
      check("zero_done", 64'({O_valid, O_done, O_busy}), 64'(3'b011));
      @(negedge I_clk);
      check("zero_idle", 64'({O_valid, O_done, O_busy}), 64'(3'b000));
      nobs = 0;
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 4000) begin
      check("beat", pack_out(), exp_q[idx]);
      v_s = O_valid;
      rd  = ($urandom_range(99) < rdy);
      if (rd && v_s) obs_q.push_back(O_addr);
      I_ready = rd;
      I_start = poke && (idx == 2);
      @(negedge I_clk);
      cyc++;
      if (rd && v_s) idx++;
    end
    I_start = 1'b0;
    I_ready = 1'b0;
    if (idx < exp_q.size()) begin
      n_checks++;
      n_errs++;
      $display("FAIL beat_timeout: got %0d beats required %0d", idx, exp_q.size());
    end
    check("done_pulse", 64'({O_valid, O_done, O_busy}), 64'(3'b011));
    @(negedge I_clk);
    check("back_idle", 64'({O_valid, O_done, O_busy}), 64'(3'b000));
    nobs = obs_q.size();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nobs, cu, ru, chu;
    sweep_addr = '{16'h100, 16'h101, 16'h102, 16'h110, 16'h111, 16'h112,
                   16'h140, 16'h141, 16'h142, 16'h150, 16'h151, 16'h152};
    vecs[0] = '{3, 2, 2, 16'h0100, 16'h0010, 16'h0040, 100, 1'b0, 12, 16'h0100, 16'h0152};
    vecs[1] = '{3, 2, 2, 16'h0100, 16'h0010, 16'h0040,  50, 1'b0, 12, 16'h0100, 16'h0152};
    vecs[2] = '{1, 1, 1, 16'h0234, 16'h0010, 16'h0040, 100, 1'b0,  1, 16'h0234, 16'h0234};
    vecs[3] = '{0, 2, 2, 16'h0100, 16'h0010, 16'h0040, 100, 1'b0,  0, 16'h0000, 16'h0000};
    vecs[4] = '{3, 2, 2, 16'h0100, 16'h0010, 16'h0040, 100, 1'b1, 12, 16'h0100, 16'h0152};
    vecs[5] = '{4, 1, 1, 16'hFFFE, 16'h0010, 16'h0040, 100, 1'b0,  4, 16'hFFFE, 16'h0001};
    vecs[6] = '{2, 3, 1, 16'h0010, 16'h0100, 16'h0007,  70, 1'b0,  6, 16'h0010, 16'h0211};
    vecs[7] = '{5, 1, 3, 16'h0000, 16'h1000, 16'h0020,  60, 1'b0, 15, 16'h0000, 16'h0044};
    vecs[8] = '{2, 2, 0, 16'h0100, 16'h0010, 16'h0040, 100, 1'b0,  0, 16'h0000, 16'h0000};

    I_rst_n = 1'b0;
    I_start = 1'b0;
    I_ready = 1'b0;
    I_col_upper = '0; I_row_upper = '0; I_ch_upper = '0;
    I_base_addr = '0; I_row_stride = '0; I_ch_stride = '0;
    #1;
    check("reset_outputs", pack_out(), 64'd0);
    repeat (2) @(negedge I_clk);
    I_rst_n = 1'b1;
    @(negedge I_clk);
    check("idle_after_reset", pack_out(), 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_cfg(vecs[i].cu, vecs[i].ru, vecs[i].chu, vecs[i].base, vecs[i].rs, vecs[i].cs,
              vecs[i].rdy, vecs[i].poke, nobs);
      check($sformatf("vec%0d_beats", i), 64'(nobs), 64'(vecs[i].exp_beats));
      if (vecs[i].exp_beats > 0 && nobs > 0) begin
        check($sformatf("vec%0d_first", i), 64'(obs_q[0]), 64'(vecs[i].exp_first));
        check($sformatf("vec%0d_last", i), 64'(obs_q[$]), 64'(vecs[i].exp_last));
      end
      if (vecs[i].exp_beats == 12 && nobs == 12)
        for (int j = 0; j < 12; j++)
          check($sformatf("vec%0d_addr%0d", i, j), 64'(obs_q[j]), 64'(sweep_addr[j]));
    end

    // Abort mid-run with asynchronous reset: outputs clear immediately and no done follows.
    @(negedge I_clk);
    I_col_upper = 8'd3; I_row_upper = 8'd2; I_ch_upper = 8'd2;
    I_base_addr = 16'h0100; I_row_stride = 16'h0010; I_ch_stride = 16'h0040;
    I_start = 1'b1;
    @(negedge I_clk);
    I_start = 1'b0;
    I_ready = 1'b1;
    repeat (5) @(negedge I_clk);
    check("pre_reset_beat5", 64'({O_valid, O_addr}), 64'({1'b1, 16'h0112}));
    #2 I_rst_n = 1'b0;
    #1 check("async_reset", pack_out(), 64'd0);
    repeat (3) begin
      @(negedge I_clk);
      check("reset_no_done", 64'({O_valid, O_done, O_busy}), 64'd0);
    end
    I_ready = 1'b0;
    I_rst_n = 1'b1;
    run_cfg(3, 2, 2, 16'h0100, 16'h0010, 16'h0040, 100, 1'b0, nobs);
    check("restart_beats", 64'(nobs), 64'd12);
    if (nobs > 0) check("restart_first", 64'(obs_q[0]), 64'h100);

    for (int i = 0; i < 25; i++) begin
      cu  = $urandom_range(4);
      ru  = $urandom_range(4);
      chu = $urandom_range(4);
      run_cfg(cu, ru, chu, 16'($urandom), 16'($urandom), 16'($urandom),
              int'($urandom_range(100, 30)), 1'($urandom_range(1)), nobs);
      check($sformatf("rand%0d_beats", i), 64'(nobs), 64'(cu * ru * chu));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
